pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_chunk.sv | 14 +
 rtl/pipelined_adder.sv | 106 ++++++++++
 tb/tb_pipelined_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults, operation encoding and helpers for the pipelined adder.
package adder_pkg;
   localparam int ADDER_WIDTH_DEF  = 16;
   localparam int ADDER_STAGES_DEF = 4;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int n = v - 1; n > 0; n = n >> 1) r++;
      return r;
   endfunction
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational W-bit add with carry in/out and the carry into the MSB.
module adder_chunk #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         ci_i,
   output logic [W-1:0] s_o,
   output logic         co_o,
   output logic         cmsb_o
);
   assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
   assign cmsb_o = s_o[W-1] ^ a_i[W-1] ^ b_i[W-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked add/subtract with valid/ready backpressure.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = ADDER_WIDTH_DEF,
   parameter int STAGES = ADDER_STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CHUNK = WIDTH / STAGES;
   logic              adv;
   logic [WIDTH-1:0]  b_eff;
   logic              c0;
   logic [STAGES-1:0] v_q, c_q, v_in, c_in, c_out, cm;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  a_in [STAGES];
   logic [WIDTH-1:0]  b_in [STAGES];
   logic [WIDTH-1:0]  s_in [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   assign b_eff     = (sub == OP_SUB) ? ~b : b;
   assign c0        = (sub == OP_SUB) ? 1'b1 : ci;
   assign adv       = !v_q[STAGES-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign co        = c_q[STAGES-1];
   // Operands shift down one chunk per stage so every stage adds the low chunk.
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      logic [CHUNK-1:0] r;
      logic [WIDTH-1:0] sd;
      if (k == 0) begin : g_first
         assign v_in[k] = in_valid;
         assign c_in[k] = c0;
         assign a_in[k] = a;
         assign b_in[k] = b_eff;
         assign s_in[k] = '0;
      end else begin : g_next
         assign v_in[k] = v_q[k-1];
         assign c_in[k] = c_q[k-1];
         assign a_in[k] = a_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign s_in[k] = s_q[k-1];
      end
      adder_chunk #(.W(CHUNK)) u_chunk (
         .a_i    (a_in[k][CHUNK-1:0]),
         .b_i    (b_in[k][CHUNK-1:0]),
         .ci_i   (c_in[k]),
         .s_o    (r),
         .co_o   (c_out[k]),
         .cmsb_o (cm[k])
      );
      always_comb begin
         sd = s_in[k];
         sd[k*CHUNK +: CHUNK] = r;
      end
      assign s_d[k] = sd;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         c_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            s_q[i] <= '0;
         end
      end else if (adv) begin
         v_q <= v_in;
         c_q <= c_out;
         for (int i = 0; i < STAGES; i++) begin
            a_q[i] <= a_in[i] >> CHUNK;
            b_q[i] <= b_in[i] >> CHUNK;
            s_q[i] <= s_d[i];
         end
      end
   end
`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_q, ovf_d;
   assign ovf_d = cm[STAGES-1] ^ c_out[STAGES-1];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else if (adv) ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`endif
   logic unused_ok;
   assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1], cm};
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder against an arithmetic model.
module tb_pipelined_adder;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, ci = 1'b0, sub = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, co;
   logic [15:0] a = '0, b = '0, sum;
`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf;
   localparam logic [17:0] MASK = 18'h3FFFF;
`else
   localparam logic [17:0] MASK = 18'h1FFFF;
`endif
   int tests = 0, fails = 0, pops = 0;
   logic [17:0] q[$];
   logic [17:0] exp_r, hg;
   logic hold = 1'b0;

   pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .co(co)
`ifdef PIPELINED_ADDER_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Result as {ovf, co, sum} from signed/unsigned integer arithmetic.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
      int ux, uy, sx, sy, u, v;
      logic cout, o;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      u = s ? ux - uy : ux + uy + int'(c);
      v = s ? sx - sy : sx + sy + int'(c);
      cout = s ? (ux >= uy) : (u > 65535);
      o = (v > 32767) || (v < -32768);
      return {o, cout, 16'(u)};
   endfunction

   function automatic logic [17:0] got();
`ifdef PIPELINED_ADDER_OVF_EN
      return {ovf, co, sum};
`else
      return {1'b0, co, sum};
`endif
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'(got()), 32'(hg));
         end
         if (in_valid && in_ready) q.push_back(model(a, b, ci, sub));
         if (out_valid && out_ready) begin
            pops++;
            if (q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
            else begin
               exp_r = q.pop_front();
               chk("result", 32'(got()), 32'(exp_r & MASK));
            end
         end
         hold = out_valid && !out_ready;
         hg = got();
      end
   end

   task automatic run1(input string nm, input logic [15:0] x, input logic [15:0] y, input logic c, input logic s, input logic [17:0] e);
      int lat;
      @(posedge clk); #1;
      out_ready = 1'b1; a = x; b = y; ci = c; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_lat"}, 32'(lat), 32'd4);
      chk({nm, "_res"}, 32'(got()), 32'(e & MASK));
   endtask

   task automatic push(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
      a = x; b = y; ci = c; sub = s; in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      chk("push_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   function automatic logic [15:0] pick();
      case ($urandom % 8)
         0: return 16'hFFFF;
         1: return 16'h0000;
         2: return 16'h8000;
         3: return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] sa, sb;
      logic sc, ss;
      int p0, stale;
      logic obs;
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_co", 32'(co), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;

      chk("pin_add", 32'(model(16'h1234, 16'h0FED, 1'b1, 1'b0)), 32'h02222);
      chk("pin_sub", 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);
      chk("pin_subovf", 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h37FFF);
      chk("pin_wrap", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h10000);

      run1("add", 16'h1234, 16'h0FED, 1'b1, 1'b0, 18'h02222);
      run1("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
      run1("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 18'h37FFF);
      run1("cross_chunk", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 18'h01000);
      run1("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
      run1("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
      drain();

      p0 = pops;
      out_ready = 1'b1;
      for (int n = 0; n < 8; n++) push(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      out_ready = 1'b0;
      sa = 16'($urandom); sb = 16'($urandom); sc = 1'($urandom); ss = 1'($urandom);
      a = sa; b = sb; ci = sc; sub = ss; in_valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      push(sa, sb, sc, ss);
      drain();
      chk("stream_count", 32'(pops - p0), 32'd9);

      for (int i = 0; i < 12; i++) begin
         in_valid = (i < 4) && (i % 2 == 0);
         @(negedge clk);
         obs = out_valid;
         chk("bubble", 32'(obs), 32'((i >= 4) && (i < 8) && (i % 2 == 0)));
         @(posedge clk); #1;
      end
      drain();

      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         in_valid = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         a = pick(); b = pick(); ci = 1'($urandom); sub = 1'($urandom);
      end
      drain();

      out_ready = 1'b0;
      for (int n = 0; n < 3; n++) push(pick(), pick(), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      chk("rst_mid_pre", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_res", 32'(got()), 32'd0);
      chk("rst_mid_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      stale = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("rst_stale", 32'(stale), 32'd0);
      chk("rst_after_ready", 32'(in_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
